// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared states, symbol codes and segment patterns for the sequence game
// Contents:
//   state_t        controller states (IDLE .. BOOM)
//   SYM0..SYM3     one-hot-low symbol codes as produced by the entry stage
//   SEG_SYM0..3    7-segment patterns (gfedcba, active-high) for each symbol
//   sym_to_seg()   symbol code to segment pattern, blank for invalid codes
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHOW    = 3'd1,
    ENTER   = 3'd2,
    CHECK   = 3'd3,
    LOCKOUT = 3'd4,
    DEFUSED = 3'd5,
    BOOM    = 3'd6
  } state_t;

  localparam logic [3:0] SYM0 = 4'b1110;
  localparam logic [3:0] SYM1 = 4'b1101;
  localparam logic [3:0] SYM2 = 4'b1011;
  localparam logic [3:0] SYM3 = 4'b0111;

  localparam logic [6:0] SEG_SYM0  = 7'b0000001;
  localparam logic [6:0] SEG_SYM1  = 7'b0000010;
  localparam logic [6:0] SEG_SYM2  = 7'b0000100;
  localparam logic [6:0] SEG_SYM3  = 7'b0001000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] sym_to_seg(input logic [3:0] sym);
    case (sym)
      SYM0:    return SEG_SYM0;
      SYM1:    return SEG_SYM1;
      SYM2:    return SEG_SYM2;
      SYM3:    return SEG_SYM3;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seq_checker_btn_sync_edge.sv
// rtl/seq_checker_btn_sync_edge.sv - two-flop synchronizer with rising-edge pulse for a raw button
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   btn    in   raw asynchronous button level
//   press  out  one-cycle pulse on each synchronized rising edge
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // A held button yields a single pulse: prev catches up one cycle after sync2 rises.
  assign press = sync2 & ~prev;

endmodule

// File: rtl/seq_checker.sv
// rtl/seq_checker.sv - shows a 4-symbol target, captures player entries, tracks strikes, declares outcome
// Optional feature macro: SEQ_CHK_LOCKOUT_EN (adds a LOCKOUT pause after a non-fatal wrong attempt)
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   target_seq     in   16-bit target, nibble k = symbol k, latched on start in IDLE
//   start          in   one-cycle pulse that begins a round from IDLE
//   entry_code     in   current symbol from the entry stage
//   btn_next       in   raw asynchronous Next button
//   timer_expired  in   countdown timer expiry level
//   display        out  high while the target is shown
//   entry_idx      out  slot the next capture writes
//   strikes        out  wrong attempts so far
//   busy           out  high outside IDLE, DEFUSED and BOOM
//   defused        out  success flag, held until reset
//   exploded       out  failure flag, held until reset
module seq_checker
  import seq_pkg::*;
#(
  parameter int SHOW_CYCLES    = 100,
  parameter int CNT_W          = 32,
  parameter int MAX_STRIKES    = 3
`ifdef SEQ_CHK_LOCKOUT_EN
  , parameter int LOCKOUT_CYCLES = 50
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] target_seq,
  input  logic        start,
  input  logic [3:0]  entry_code,
  input  logic        btn_next,
  input  logic        timer_expired,
  output logic        display,
  output logic [1:0]  entry_idx,
  output logic [1:0]  strikes,
  output logic        busy,
  output logic        defused,
  output logic        exploded
);

  state_t           state_q, state_nx;
  logic [15:0]      target_q, target_nx;
  logic [15:0]      captured_q, captured_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [1:0]       idx_q, idx_nx;
  logic [1:0]       strikes_q, strikes_nx;
  logic             press;

  btn_sync_edge u_next_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_next),
    .press (press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      target_q   <= 16'h0000;
      captured_q <= 16'hFFFF;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      strikes_q  <= 2'd0;
    end else begin
      state_q    <= state_nx;
      target_q   <= target_nx;
      captured_q <= captured_nx;
      cnt_q      <= cnt_nx;
      idx_q      <= idx_nx;
      strikes_q  <= strikes_nx;
    end
  end

  always_comb begin
    state_nx    = state_q;
    target_nx   = target_q;
    captured_nx = captured_q;
    cnt_nx      = cnt_q;
    idx_nx      = idx_q;
    strikes_nx  = strikes_q;
    display     = 1'b0;
    busy        = 1'b1;
    defused     = 1'b0;
    exploded    = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          target_nx  = target_seq;
          strikes_nx = 2'd0;
          cnt_nx     = '0;
          state_nx   = SHOW;
        end
      end

      SHOW: begin
        display = 1'b1;
        if (timer_expired) begin
          state_nx = BOOM;
        end else if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
          cnt_nx   = '0;
          idx_nx   = 2'd0;
          state_nx = ENTER;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end

      ENTER: begin
        // Timer expiry wins over a press landing in the same cycle.
        if (timer_expired) begin
          state_nx = BOOM;
        end else if (press) begin
          captured_nx[{idx_q, 2'b00} +: 4] = entry_code;
          idx_nx = idx_q + 2'd1;
          if (idx_q == 2'd3) state_nx = CHECK;
        end
      end

      CHECK: begin
        if (timer_expired) begin
          state_nx = BOOM;
        end else if (captured_q == target_q) begin
          state_nx = DEFUSED;
        end else begin
          strikes_nx = strikes_q + 2'd1;
          cnt_nx     = '0;
          if (strikes_nx == 2'(MAX_STRIKES)) begin
            state_nx = BOOM;
          end else begin
`ifdef SEQ_CHK_LOCKOUT_EN
            state_nx = LOCKOUT;
`else
            state_nx = SHOW;
`endif
          end
        end
      end

`ifdef SEQ_CHK_LOCKOUT_EN
      LOCKOUT: begin
        if (timer_expired) begin
          state_nx = BOOM;
        end else if (cnt_q == CNT_W'(LOCKOUT_CYCLES - 1)) begin
          cnt_nx   = '0;
          state_nx = SHOW;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
`endif

      DEFUSED: begin
        busy    = 1'b0;
        defused = 1'b1;
      end

      BOOM: begin
        busy     = 1'b0;
        exploded = 1'b1;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign entry_idx = idx_q;
  assign strikes   = strikes_q;

endmodule

// File: tb/tb_seq_checker.sv
// tb/tb_seq_checker.sv - scoreboard bench for seq_checker with randomized rounds
module tb_seq_checker;

  localparam int SHOW = 100;
  localparam int MAXS = 3;
  localparam int LOCK = 50;

  logic        clk, reset;
  logic [15:0] target_seq;
  logic        start;
  logic [3:0]  entry_code;
  logic        btn_next, timer_expired;
  logic        display, busy, defused, exploded;
  logic [1:0]  entry_idx, strikes;

  seq_checker #(
    .SHOW_CYCLES (SHOW),
    .CNT_W       (32),
    .MAX_STRIKES (MAXS)
`ifdef SEQ_CHK_LOCKOUT_EN
    , .LOCKOUT_CYCLES (LOCK)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .target_seq    (target_seq),
    .start         (start),
    .entry_code    (entry_code),
    .btn_next      (btn_next),
    .timer_expired (timer_expired),
    .display       (display),
    .entry_idx     (entry_idx),
    .strikes       (strikes),
    .busy          (busy),
    .defused       (defused),
    .exploded      (exploded)
  );

  typedef struct packed {
    logic       d;
    logic [1:0] idx;
    logic [1:0] s;
    logic       b;
    logic       df;
    logic       ex;
  } obs_t;

  typedef struct {
    obs_t  o;
    int    c;
    string name;
  } exp_t;

  exp_t        q[$];
  obs_t        exp_now, m_last, m_cur;
  exp_t        m_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [3:0]  m_target[4];
  int          m_strikes;
  bit          m_done;
  logic [3:0]  sym[4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  function automatic obs_t mk(input logic d, input int idx, input int s,
                              input logic b, input logic df, input logic ex);
    return {d, 2'(idx), 2'(s), b, df, ex};
  endfunction

  task automatic push(input obs_t o, input int c, input string name);
    exp_t e;
    e.o = o; e.c = c; e.name = name;
    q.push_back(e);
    exp_now = o;
  endtask

  // Monitor: every change of the visible output tuple must match the next expectation.
  initial m_last = '0;
  always @(negedge clk) begin
    m_cur = {display, entry_idx, strikes, busy, defused, exploded};
    if (m_cur !== m_last) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_change got=%h cyc=%0d", m_cur, cyc);
      end else begin
        m_e = q.pop_front();
        check({m_e.name, "_outputs"}, 32'(m_cur), 32'(m_e.o));
        if (m_e.c >= 0) check({m_e.name, "_cycle"}, 32'(cyc), 32'(m_e.c));
      end
      m_last = m_cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one Next press; optionally raises timer_expired in the cycle the press would be captured.
  task automatic press(input logic [3:0] code, input int hold, input bit timer_hit);
    entry_code = code;
    btn_next   = 1'b1;
    for (int t = 1; t <= hold + 3; t++) begin
      tick(1);
      if (t >= hold) btn_next = 1'b0;
      timer_expired = timer_hit && (t == 2);
    end
  endtask

  task automatic start_round(input logic [15:0] t, input bit press_in_show);
    int a;
    a = cyc;
    for (int k = 0; k < 4; k++) m_target[k] = t[4*k +: 4];
    m_strikes = 0;
    m_done    = 0;
    push(mk(1, 0, 0, 1, 0, 0), a + 1, "show");
    push(mk(0, 0, 0, 1, 0, 0), a + 1 + SHOW, "enter");
    target_seq = t;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    target_seq = 16'($urandom);
    if (press_in_show) press(sym[$urandom_range(0, 3)], $urandom_range(1, 20), 1'b0);
    while (cyc < a + 2 + SHOW) tick(1);
  endtask

  task automatic attempt(input logic [15:0] ent, input int hold0, input bit timer_last);
    int a, done_c, hold;
    bit match;
    match = 1;
    for (int k = 0; k < 4; k++) if (ent[4*k +: 4] !== m_target[k]) match = 0;
    done_c = 0;
    for (int k = 0; k < 4; k++) begin
      a = cyc;
      if (k < 3) begin
        push(mk(0, k + 1, m_strikes, 1, 0, 0), a + 3, "capture");
      end else if (timer_last) begin
        push(mk(0, 3, m_strikes, 0, 0, 1), a + 3, "timer_boom");
        m_done = 1; done_c = a + 5;
      end else begin
        push(mk(0, 0, m_strikes, 1, 0, 0), a + 3, "check");
        if (match) begin
          push(mk(0, 0, m_strikes, 0, 1, 0), a + 4, "defused");
          m_done = 1; done_c = a + 6;
        end else begin
          m_strikes++;
          if (m_strikes == MAXS) begin
            push(mk(0, 0, m_strikes, 0, 0, 1), a + 4, "boom");
            m_done = 1; done_c = a + 6;
          end else begin
`ifdef SEQ_CHK_LOCKOUT_EN
            push(mk(0, 0, m_strikes, 1, 0, 0), a + 4, "lockout");
            push(mk(1, 0, m_strikes, 1, 0, 0), a + 4 + LOCK, "replay");
            push(mk(0, 0, m_strikes, 1, 0, 0), a + 4 + LOCK + SHOW, "reenter");
            done_c = a + 5 + LOCK + SHOW;
`else
            push(mk(1, 0, m_strikes, 1, 0, 0), a + 4, "replay");
            push(mk(0, 0, m_strikes, 1, 0, 0), a + 4 + SHOW, "reenter");
            done_c = a + 5 + SHOW;
`endif
          end
        end
      end
      hold = (k == 0) ? hold0 : int'($urandom_range(1, 4));
      press(ent[4*k +: 4], hold, timer_last && (k == 3));
    end
    // A press now lands in SHOW/LOCKOUT or a terminal state and must change nothing.
    press(sym[$urandom_range(0, 3)], 2, 1'b0);
    if (m_done) begin
      start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    while (cyc < done_c) tick(1);
  endtask

  task automatic do_reset();
    if (exp_now != '0) push('0, -1, "reset");
    #2 reset = 1'b0;
    #1 check("async_reset", 32'({display, entry_idx, strikes, busy, defused, exploded}), 32'h0);
    tick(2);
    reset = 1'b1;
    tick(1);
    m_strikes = 0;
    m_done = 0;
  endtask

  function automatic logic [15:0] wrong_of(input logic [15:0] t);
    logic [15:0] w;
    int s;
    w = t;
    s = $urandom_range(0, 3);
    w[4*s +: 4] = w[4*s +: 4] ^ 4'($urandom_range(1, 15));
    return w;
  endfunction

  initial begin
    logic [15:0] t, ent;
    reset = 1'b1; start = 1'b0; target_seq = '0; entry_code = '0;
    btn_next = 1'b0; timer_expired = 1'b0; exp_now = '0; m_strikes = 0; m_done = 0;
    #1 reset = 1'b0;
    #2 check("reset_state", 32'({display, entry_idx, strikes, busy, defused, exploded}), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick(2);

    // Correct entry
    start_round(16'h7BDE, 0);
    attempt(16'h7BDE, 2, 0);
    do_reset();

    // Wrong entry then correct
    start_round(16'h7BDE, 0);
    attempt(16'h7BEE, 1, 0);
    attempt(16'h7BDE, 3, 0);
    do_reset();

    // Three wrong attempts, including a non-symbol nibble
    start_round(16'h7BDE, 0);
    attempt(16'h7BEE, 1, 0);
    attempt(16'hFFFF, 2, 0);
    attempt(16'hE7BD, 1, 0);
    do_reset();

    // Press during SHOW, held first press, timer on the final press
    start_round(16'h7BDE, 1);
    attempt(16'h7BDE, 20, 1);
    do_reset();

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) t[4*k +: 4] = sym[$urandom_range(0, 3)];
      start_round(t, bit'($urandom_range(0, 1)));
      while (!m_done) begin
        ent = ($urandom_range(0, 1) == 1) ? wrong_of(t) : t;
        attempt(ent, $urandom_range(1, 8), $urandom_range(0, 9) == 0);
      end
      do_reset();
    end

    tick(3);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
